// File: rtl/divmul_wb_scheduler_if.sv
// Issue/writeback bundle between the mul/div issue selects and the shared
// writeback-port scheduler.
interface divmul_wb_scheduler_if #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned MAX_DIV = 8
);
  localparam int unsigned CNT_W = $clog2(MAX_DIV + 1);

  logic             flush_back;
  logic             div_req;
  logic [TAG_W-1:0] div_tag_rob;
  logic             div_grant;
  logic             mul_req;
  logic [TAG_W-1:0] mul_tag_rob;
  logic             mul_grant;
  logic             wb_valid;
  logic             wb_src;
  logic [TAG_W-1:0] wb_tag_rob;
  logic [CNT_W-1:0] div_inflight;

  modport master (
    output flush_back, div_req, div_tag_rob, mul_req, mul_tag_rob,
    input  div_grant, mul_grant, wb_valid, wb_src, wb_tag_rob, div_inflight
  );

  modport slave (
    input  flush_back, div_req, div_tag_rob, mul_req, mul_tag_rob,
    output div_grant, mul_grant, wb_valid, wb_src, wb_tag_rob, div_inflight
  );
endinterface

// File: rtl/divmul_wb_scheduler.sv
// Issue grant and writeback-port reservation for a pipelined divider and
// multiplier that share one result port into the ROB writeback stage.
module divmul_wb_scheduler #(
  parameter int unsigned DIV_TIME = 16,
  parameter int unsigned MUL_TIME = 3,
  parameter int unsigned MAX_DIV  = 8,
  parameter int unsigned TAG_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  divmul_wb_scheduler_if.slave    bus
);
  localparam int unsigned CNT_W = $clog2(MAX_DIV + 1);

  if (MUL_TIME < 1 || MUL_TIME >= DIV_TIME || MAX_DIV > DIV_TIME) begin : g_bad_param
    $error("divmul_wb_scheduler: illegal latency or in-flight limit");
  end

  // Entry 0 is the writeback output register; entry k is the port k cycles later.
  logic [DIV_TIME-1:0] slot_v_q,   slot_v_d;
  logic [DIV_TIME-1:0] slot_src_q, slot_src_d;
  logic [TAG_W-1:0]    slot_tag_q [DIV_TIME];
  logic [TAG_W-1:0]    slot_tag_d [DIV_TIME];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                div_grant_c, mul_grant_c;

  // Grants: divide is limited only by the in-flight cap; multiply stalls if the
  // entry shifting into its landing slot is already held by a divide.
  always_comb begin
    div_grant_c = bus.div_req & ~bus.flush_back & ~rst & (cnt_q < CNT_W'(MAX_DIV));
    mul_grant_c = bus.mul_req & ~bus.flush_back & ~rst & ~slot_v_q[MUL_TIME];
  end

  always_comb begin
    slot_v_d   = '0;
    slot_src_d = '0;
    for (int unsigned i = 0; i < DIV_TIME; i++) begin
      slot_tag_d[i] = '0;
    end
    cnt_d = '0;
    if (!bus.flush_back) begin
      for (int unsigned i = 0; i < DIV_TIME - 1; i++) begin
        slot_v_d[i]   = slot_v_q[i+1];
        slot_src_d[i] = slot_src_q[i+1];
        slot_tag_d[i] = slot_tag_q[i+1];
      end
      slot_v_d[DIV_TIME-1]   = div_grant_c;
      slot_src_d[DIV_TIME-1] = 1'b1;
      slot_tag_d[DIV_TIME-1] = bus.div_tag_rob;
      if (mul_grant_c) begin
        slot_v_d[MUL_TIME-1]   = 1'b1;
        slot_src_d[MUL_TIME-1] = 1'b0;
        slot_tag_d[MUL_TIME-1] = bus.mul_tag_rob;
      end
      cnt_d = cnt_q + CNT_W'(div_grant_c) - CNT_W'(slot_v_q[0] & slot_src_q[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q   <= '0;
      slot_src_q <= '0;
      for (int unsigned i = 0; i < DIV_TIME; i++) begin
        slot_tag_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_src_q <= slot_src_d;
      slot_tag_q <= slot_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.div_grant    = div_grant_c;
  assign bus.mul_grant    = mul_grant_c;
  assign bus.wb_valid     = slot_v_q[0];
  assign bus.wb_src       = slot_src_q[0];
  assign bus.wb_tag_rob   = slot_tag_q[0];
  assign bus.div_inflight = cnt_q;
endmodule

// File: tb/tb_divmul_wb_scheduler.sv
// Directed bench for divmul_wb_scheduler: latency, conflict stall, divide cap,
// mixed traffic against a port-occupancy model, flush and mid-stream reset.
module tb_divmul_wb_scheduler;
  localparam int unsigned DT = 16;
  localparam int unsigned MT = 3;
  localparam int unsigned MD = 8;
  localparam int unsigned TW = 6;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  divmul_wb_scheduler_if #(.TAG_W(TW), .MAX_DIV(MD)) bus ();

  divmul_wb_scheduler #(
    .DIV_TIME(DT), .MUL_TIME(MT), .MAX_DIV(MD), .TAG_W(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Occupancy model for the mixed-traffic phase
  logic          mv [0:79];
  logic          ms [0:79];
  logic [TW-1:0] mt [0:79];
  int            mcnt;
  logic          edg, emg;
  int            e;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_back  = 1'b0;
    bus.div_req     = 1'b0;
    bus.div_tag_rob = '0;
    bus.mul_req     = 1'b0;
    bus.mul_tag_rob = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and grants held low during reset
    idle_inputs();
    rst = 1'b1;
    bus.div_req = 1'b1;
    bus.mul_req = 1'b1;
    tick();
    tick();
    chk("rst div_grant", 32'(bus.div_grant), 0);
    chk("rst mul_grant", 32'(bus.mul_grant), 0);
    chk("rst wb_valid", 32'(bus.wb_valid), 0);
    chk("rst wb_src", 32'(bus.wb_src), 0);
    chk("rst wb_tag", 32'(bus.wb_tag_rob), 0);
    chk("rst inflight", 32'(bus.div_inflight), 0);

    // Single divide granted at cycle 10
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      bus.div_req     = (c == 10);
      bus.div_tag_rob = 6'h05;
      #1;
      if (c == 10) chk("t1 div_grant", 32'(bus.div_grant), 1);
      chk($sformatf("t1 wb_valid c%0d", c), 32'(bus.wb_valid), 32'(c == 26));
      if (c == 26) begin
        chk("t1 wb_src", 32'(bus.wb_src), 1);
        chk("t1 wb_tag", 32'(bus.wb_tag_rob), 32'h05);
      end
      chk($sformatf("t1 inflight c%0d", c), 32'(bus.div_inflight), 32'(c >= 11 && c <= 26));
      tick();
    end

    // Multiply stalls one cycle behind a divide landing on the same port cycle
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      bus.div_req     = (c == 0);
      bus.div_tag_rob = 6'h11;
      bus.mul_req     = (c == 13 || c == 14);
      bus.mul_tag_rob = 6'h22;
      #1;
      if (c == 0)  chk("t2 div_grant", 32'(bus.div_grant), 1);
      if (c == 13) chk("t2 mul_grant stall", 32'(bus.mul_grant), 0);
      if (c == 14) chk("t2 mul_grant go", 32'(bus.mul_grant), 1);
      chk($sformatf("t2 wb_valid c%0d", c), 32'(bus.wb_valid), 32'(c == 16 || c == 17));
      if (c == 16) begin
        chk("t2 div wb_src", 32'(bus.wb_src), 1);
        chk("t2 div wb_tag", 32'(bus.wb_tag_rob), 32'h11);
      end
      if (c == 17) begin
        chk("t2 mul wb_src", 32'(bus.wb_src), 0);
        chk("t2 mul wb_tag", 32'(bus.wb_tag_rob), 32'h22);
      end
      tick();
    end

    // Divide cap: grants 0-7, blocked until after the first writeback
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      bus.div_req     = (c < 12) || (c == 16) || (c == 17);
      bus.div_tag_rob = TW'(c);
      #1;
      chk($sformatf("t3 div_grant c%0d", c), 32'(bus.div_grant), 32'((c < 8) || (c == 17)));
      if (c <= 8)       e = c;
      else if (c <= 16) e = 8;
      else if (c <= 18) e = 7;
      else              e = 6;
      chk($sformatf("t3 inflight c%0d", c), 32'(bus.div_inflight), 32'(e));
      if (c >= 16) begin
        chk($sformatf("t3 wb_valid c%0d", c), 32'(bus.wb_valid), 1);
        chk($sformatf("t3 wb_tag c%0d", c), 32'(bus.wb_tag_rob), 32'(c - 16));
      end
      tick();
    end

    // Both units requesting every cycle, then drain, against the port model
    do_reset();
    for (int i = 0; i < 80; i++) begin
      mv[i] = 1'b0;
      ms[i] = 1'b0;
      mt[i] = '0;
    end
    mcnt = 0;
    for (int c = 0; c < 60; c++) begin
      bus.div_req     = (c < 40);
      bus.div_tag_rob = TW'(c);
      bus.mul_req     = (c < 40);
      bus.mul_tag_rob = TW'(c + 20);
      #1;
      edg = (c < 40) && (mcnt < int'(MD));
      emg = (c < 40) && !mv[c + int'(MT)];
      chk($sformatf("t4 div_grant c%0d", c), 32'(bus.div_grant), 32'(edg));
      chk($sformatf("t4 mul_grant c%0d", c), 32'(bus.mul_grant), 32'(emg));
      chk($sformatf("t4 wb_valid c%0d", c), 32'(bus.wb_valid), 32'(mv[c]));
      if (mv[c]) begin
        chk($sformatf("t4 wb_src c%0d", c), 32'(bus.wb_src), 32'(ms[c]));
        chk($sformatf("t4 wb_tag c%0d", c), 32'(bus.wb_tag_rob), 32'(mt[c]));
      end
      chk($sformatf("t4 inflight c%0d", c), 32'(bus.div_inflight), 32'(mcnt));
      if (edg) begin
        mv[c + int'(DT)] = 1'b1;
        ms[c + int'(DT)] = 1'b1;
        mt[c + int'(DT)] = TW'(c);
      end
      if (emg) begin
        mv[c + int'(MT)] = 1'b1;
        ms[c + int'(MT)] = 1'b0;
        mt[c + int'(MT)] = TW'(c + 20);
      end
      mcnt = mcnt + int'(edg) - int'(mv[c] && ms[c]);
      tick();
    end

    // Flush at cycle 8 with three divides and one multiply outstanding
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      bus.div_req     = (c <= 2) || (c == 8);
      bus.div_tag_rob = TW'(c + 1);
      bus.mul_req     = (c == 6) || (c == 8);
      bus.mul_tag_rob = 6'h09;
      bus.flush_back  = (c == 8);
      #1;
      if (c <= 2) chk($sformatf("t5 div_grant c%0d", c), 32'(bus.div_grant), 1);
      if (c == 6) chk("t5 mul_grant", 32'(bus.mul_grant), 1);
      if (c == 8) begin
        chk("t5 flush div_grant", 32'(bus.div_grant), 0);
        chk("t5 flush mul_grant", 32'(bus.mul_grant), 0);
        chk("t5 inflight pre", 32'(bus.div_inflight), 3);
      end
      if (c >= 9) begin
        chk($sformatf("t5 wb_valid c%0d", c), 32'(bus.wb_valid), 0);
        chk($sformatf("t5 inflight c%0d", c), 32'(bus.div_inflight), 0);
      end
      if (c == 9) begin
        chk("t5 wb_src", 32'(bus.wb_src), 0);
        chk("t5 wb_tag", 32'(bus.wb_tag_rob), 0);
      end
      tick();
    end
    bus.flush_back = 1'b0;

    // Reset high for cycles 5-6 mid-stream, fresh divide at 7
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      rst             = (c == 5) || (c == 6);
      bus.div_req     = (c <= 7);
      bus.div_tag_rob = (c == 7) ? 6'h2A : TW'(c);
      bus.mul_req     = (c == 3) || (c == 5);
      bus.mul_tag_rob = 6'h30;
      #1;
      if (c == 5 || c == 6) begin
        chk($sformatf("t6 rst div_grant c%0d", c), 32'(bus.div_grant), 0);
        chk($sformatf("t6 rst mul_grant c%0d", c), 32'(bus.mul_grant), 0);
      end
      if (c == 6 || c == 7) begin
        chk($sformatf("t6 wb_valid c%0d", c), 32'(bus.wb_valid), 0);
        chk($sformatf("t6 wb_src c%0d", c), 32'(bus.wb_src), 0);
        chk($sformatf("t6 wb_tag c%0d", c), 32'(bus.wb_tag_rob), 0);
        chk($sformatf("t6 inflight c%0d", c), 32'(bus.div_inflight), 0);
      end
      if (c == 7) chk("t6 div_grant", 32'(bus.div_grant), 1);
      if (c >= 8) chk($sformatf("t6 wb_valid c%0d", c), 32'(bus.wb_valid), 32'(c == 23));
      if (c == 8) chk("t6 inflight", 32'(bus.div_inflight), 1);
      if (c == 23) begin
        chk("t6 wb_src", 32'(bus.wb_src), 1);
        chk("t6 wb_tag", 32'(bus.wb_tag_rob), 32'h2A);
      end
      if (c == 24) chk("t6 inflight drained", 32'(bus.div_inflight), 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divmul_wb_scheduler.md
Name: divmul_wb_scheduler

Overview:
- Issue-side scheduler for the fixed-latency pipelined divider (DIV_TIME cycles) and the pipelined multiplier (MUL_TIME cycles), which share one writeback port into the rename/ROB writeback stage.
- Grants issue to each unit so that no two results land on the shared port in the same cycle.
- Caps in-flight divides and drives the writeback valid/source/ROB tag in the cycle each result emerges.
- Sits between the mul/div issue queue selects and the execute units; cleared by flush_back.

Parameters:
- DIV_TIME, 16, divider latency: grant cycle t -> result on port at t+DIV_TIME.
- MUL_TIME, 3, multiplier latency; must satisfy 1 <= MUL_TIME < DIV_TIME.
- MAX_DIV, 8, maximum divides in flight; must be <= DIV_TIME.
- TAG_W, 6, ROB tag width.

Ports:
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous and active-high.
- flush_back, in, 1: backend flush (branch mispredict / exception), synchronous.
- div_req, in, 1: divide op selected for issue this cycle.
- div_tag_rob, in, TAG_W: ROB tag of the requesting divide.
- div_grant, out, 1: divide may issue this cycle (combinational).
- mul_req, in, 1: multiply op selected for issue this cycle.
- mul_tag_rob, in, TAG_W: ROB tag of the requesting multiply.
- mul_grant, out, 1: multiply may issue this cycle (combinational).
- wb_valid, out, 1: a result occupies the shared port this cycle.
- wb_src, out, 1: source of the current result; 0 = mul, 1 = div.
- wb_tag_rob, out, TAG_W: ROB tag of the current result.
- div_inflight, out, $clog2(MAX_DIV+1): count of divides granted but not yet written back.

Behaviour:
- Reservation table: slot[1..DIV_TIME]; each slot holds {v, src, tag}. slot[i] describes the port in cycle t+i.
- Per cycle, unless flushing: slot[i] <= slot[i+1] for i < DIV_TIME; slot[DIV_TIME] <= {div_grant, 1, div_tag_rob}.
- Mul insertion: when mul_grant is high, slot[MUL_TIME] <= {1, 0, mul_tag_rob}. This overrides the shift into that entry; the shifted-in value is guaranteed empty by the grant rule.
- Outputs {wb_valid, wb_src, wb_tag_rob} are registered: they equal slot[1] of the previous cycle, i.e. slot[1] before the shift.
- Result: a div granted at cycle t shows wb_valid at t+DIV_TIME; a mul granted at t shows wb_valid at t+MUL_TIME.
- div_grant = div_req & ~flush_back & ~rst & (div_inflight < MAX_DIV). No table check is needed: slot DIV_TIME is written only by the div grant.
- mul_grant = mul_req & ~flush_back & ~rst & ~slot[MUL_TIME+1].v. The check uses the entry that shifts into MUL_TIME.
- The only mul/div conflict is a div granted exactly DIV_TIME-MUL_TIME cycles earlier. The div holds the slot and the mul stalls 1 cycle.
- Both grants in the same cycle are legal; they target different slots.
- Grants depend only on req and state; there is no dependence on other outputs and no combinational loop.
- div_inflight:
  - +1 on div_grant.
  - -1 on wb_valid & wb_src == 1 (evaluated on registered outputs).
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_DIV and never underflows.
- flush_back (high in cycle t):
  - Grants forced 0 in cycle t.
  - At the clock edge all slots clear, wb_valid/wb_src/wb_tag_rob go to 0, and div_inflight goes to 0.
  - A result scheduled for t+1 is dropped. The divider pipe is flushed in the same cycle, so no orphan results exist.
- rst: same clearing as flush_back. All outputs are 0 in the cycle after rst is sampled high, and grants are 0 while rst is high. Reset mid-operation discards all reservations.
- Idle (no reqs): table drains; wb_valid returns to 0 once slot[1] is empty.
- Full (div_inflight == MAX_DIV): div_grant = 0 until a div writeback occurs. A div_req in the same cycle as that writeback is still blocked, because the check uses the current count.

Test Plan:
- Single div, tag 0x05, granted at cycle 10 (DIV_TIME=16) -> wb_valid=1, wb_src=1, wb_tag_rob=0x05 at cycle 26 only; div_inflight 1 from cycle 11 to 26, 0 at 27.
- Div granted at cycle 0, mul_req held from cycle 13 (16-3=13) -> mul_grant=0 at 13, 1 at 14; port shows div at 16 and mul at 17, never both.
- div_req every cycle for 12 cycles, MAX_DIV=8 -> grants at cycles 0-7, blocked 8-11, div_inflight stays at 8. At cycle 16 (first wb) the count holds; a new grant resumes at cycle 17.
- Div and mul both requesting every cycle for 40 cycles -> no cycle with two results. Every granted tag appears exactly once on wb_tag_rob at grant+latency, with correct wb_src.
- flush_back at cycle 8 with 3 divs and 1 mul in flight -> grants 0 at cycle 8; from cycle 9 wb_valid=0 and div_inflight=0; no stale writeback ever appears.
- rst asserted at cycle 5 mid-stream, released at 7 -> all outputs 0 at cycles 6-7; a fresh div granted at 7 writes back at 23.
